// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 (7,5) hard-decision Viterbi decoder.
package viterbi_pkg;
  localparam int K = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] state_t;

  // Encoder register is {d, a, b}; each output bit is the parity of the tapped positions.
  function automatic logic [1:0] exp_sym(input state_t s, input logic d);
    logic [2:0] w_reg;
    w_reg = {d, s};
    return {^(w_reg & G1), ^(w_reg & G0)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] w_x;
    w_x = a ^ b;
    return {w_x[1] & w_x[0], w_x[1] ^ w_x[0]};
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: keeps the cheaper of two predecessors.
module viterbi_acs #(
  parameter int PM_W  = 6,
  parameter int DEPTH = 15
) (
  input  logic [PM_W:0]    i_cand0,
  input  logic [PM_W:0]    i_cand1,
  input  logic [DEPTH-2:0] i_surv0,
  input  logic [DEPTH-2:0] i_surv1,
  input  logic             i_bit,
  output logic [PM_W:0]    o_metric,
  output logic [DEPTH-1:0] o_surv
);
  logic w_sel1;

  // Strict compare so a tie keeps the b=0 predecessor.
  assign w_sel1   = i_cand1 < i_cand0;
  assign o_metric = w_sel1 ? i_cand1 : i_cand0;
  assign o_surv   = {(w_sel1 ? i_surv1 : i_surv0), i_bit};
endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder; one decoded bit per symbol after DEPTH symbols.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int PM_W  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       data_out,
  output logic       data_valid
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [PM_W-1:0]   PM_MAX    = {PM_W{1'b1}};
  localparam logic [PM_W-1:0]   PM_ZERO   = {PM_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  // The oldest survivor bit is consumed in the cycle it is formed, so only DEPTH-1 bits are stored.
  logic [PM_W-1:0]   r_pm   [NUM_STATES];
  logic [DEPTH-2:0]  r_surv [NUM_STATES];
  logic [FILL_W-1:0] r_fill;
  logic              r_data_out;
  logic              r_data_valid;

  logic [PM_W-1:0]   w_pm_base   [NUM_STATES];
  logic [DEPTH-2:0]  w_surv_base [NUM_STATES];
  logic [FILL_W-1:0] w_fill_base;
  logic [FILL_W-1:0] w_fill_next;
  logic [PM_W:0]     w_pm_acs    [NUM_STATES];
  logic [DEPTH-1:0]  w_surv_acs  [NUM_STATES];
  logic [PM_W:0]     w_pm_diff   [NUM_STATES];
  logic [PM_W-1:0]   w_pm_norm   [NUM_STATES];
  logic [PM_W:0]     w_pm_min;
  state_t            w_best;

  // A start pulse makes this cycle's symbol run from the initial metrics.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      w_pm_base[i]   = start ? ((i == 0) ? PM_ZERO : PM_MAX) : r_pm[i];
      w_surv_base[i] = start ? '0 : r_surv[i];
    end
    w_fill_base = start ? '0 : r_fill;
  end

  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam state_t P0 = state_t'((ns % 2) * 2);
    localparam state_t P1 = state_t'((ns % 2) * 2 + 1);
    localparam logic   D  = (ns / 2) != 0;

    logic [PM_W:0] w_cand0;
    logic [PM_W:0] w_cand1;

    assign w_cand0 = {1'b0, w_pm_base[P0]} + {{(PM_W-1){1'b0}}, hamming2(sym_in, exp_sym(P0, D))};
    assign w_cand1 = {1'b0, w_pm_base[P1]} + {{(PM_W-1){1'b0}}, hamming2(sym_in, exp_sym(P1, D))};

    viterbi_acs #(.PM_W(PM_W), .DEPTH(DEPTH)) u_acs (
      .i_cand0  (w_cand0),
      .i_cand1  (w_cand1),
      .i_surv0  (w_surv_base[P0]),
      .i_surv1  (w_surv_base[P1]),
      .i_bit    (D),
      .o_metric (w_pm_acs[ns]),
      .o_surv   (w_surv_acs[ns])
    );
  end

  always_comb begin
    w_pm_min = w_pm_acs[0];
    w_best   = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (w_pm_acs[i] < w_pm_min) begin
        w_pm_min = w_pm_acs[i];
        w_best   = state_t'(i);
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      w_pm_diff[i] = w_pm_acs[i] - w_pm_min;
      w_pm_norm[i] = (w_pm_diff[i] > {1'b0, PM_MAX}) ? PM_MAX : w_pm_diff[i][PM_W-1:0];
    end
    w_fill_next = (w_fill_base == FILL_FULL) ? FILL_FULL : w_fill_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i]   <= (i == 0) ? PM_ZERO : PM_MAX;
        r_surv[i] <= '0;
      end
      r_fill       <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (sym_valid) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          r_pm[i]   <= w_pm_norm[i];
          r_surv[i] <= w_surv_acs[i][DEPTH-2:0];
        end
        r_fill <= w_fill_next;
        if (w_fill_next == FILL_FULL) begin
          r_data_out   <= w_surv_acs[w_best][DEPTH-1];
          r_data_valid <= 1'b1;
        end
      end else if (start) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          r_pm[i]   <= w_pm_base[i];
          r_surv[i] <= w_surv_base[i];
        end
        r_fill <= w_fill_base;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
endmodule
